mux_pipe_n: RTL and testbench
=============================

Name: mux_pipe_n

Overview:
- Parametrised successor to the datapath 2:1 select: an N_IN-way, WIDTH-bit operand select with a registered output stage and valid/ready handshake.
- A 1-entry skid buffer lets in_ready come from a register only, with no combinational path from out_ready.
- Sits between the register-file/forwarding sources and the ALU operand latch, where the pipeline may stall.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- N_IN, 4, number of selectable inputs (N_IN >= 2).
- SEL_W, $clog2(N_IN), width of the binary select.
- CNT_W, 16, width of the accepted-beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat (registered).
- sel  in  SEL_W  binary select, sampled with the beat.
- in_data  in  N_IN*WIDTH  flattened inputs; input k is bits [k*WIDTH +: WIDTH].
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out_data  out  WIDTH  registered selected data.
- out_sel  out  SEL_W  select that produced out_data.
- beat_cnt  out  CNT_W  count of accepted input beats; wraps.
- sel_err  out  1  sticky out-of-range select flag (see Optional Feature).

Behaviour:
- Reset (async, rst=1) forces: out_valid=0, out_data=0, out_sel=0, skid_valid=0 (so in_ready=1), beat_cnt=0, sel_err=0. Deassertion is sampled on the next clk edge.
- in_ready = !skid_valid.
- Input accept: acc = in_valid & in_ready.
- Output transfer: xfer = out_valid & out_ready.
- Mux value: in_data slice [sel], 1-cycle latency from accept to out_valid when the output stage is free.
- Register update rules, evaluated per clk edge in priority order:
  1. skid_valid & out_ready: main register loads skid (data, sel); skid_valid <= 0. No accept is possible this cycle because in_ready=0.
  2. acc & (!out_valid | out_ready): main register loads mux value; out_valid <= 1.
  3. acc & out_valid & !out_ready: skid loads mux value; skid_valid <= 1. The main register holds.
  4. xfer & !acc & !skid_valid: out_valid <= 0.
  5. Otherwise: hold.
- Stall: while out_valid & !out_ready, out_data and out_sel remain stable.
- Accept + transfer in the same cycle: passes through with no bubble, giving sustained throughput of 1 beat/cycle.
- Full: skid_valid=1 drops in_ready. in_ready returns high on the cycle after out_ready drains the skid.
- beat_cnt increments by 1 on every acc and wraps from 2^CNT_W-1 to 0. It does not count output transfers.
- Out-of-range sel (sel >= N_IN, only possible when N_IN is not a power of 2): the selected data is all-zero.
- Reset asserted mid-stall discards both the main and skid contents. No beat is replayed.

Optional Feature:
- Macro: MUX_PIPE_SEL_CHECK_EN.
- Defined:
  - An accepted beat with sel >= N_IN sets sel_err=1. It stays set until rst.
  - The beat is still passed through with zero data.
- Undefined:
  - sel_err is tied to 0.
  - No compare logic is generated.
  - Data behaviour is otherwise identical.

Decomposition:
- Package mux_pipe_pkg holds:
  - default WIDTH (32) and CNT_W (16) constants;
  - a function sel_width(n) returning $clog2(n) with a minimum of 1.
- Sub-module mux_comb_n is the purely combinational N_IN-way WIDTH-bit selector with a zero default. It is instantiated once; the skid/handshake logic stays in mux_pipe_n.

Test Plan:
- Reset then idle: rst=1 for 3 cycles -> out_valid=0, in_ready=1, beat_cnt=0, out_data=0.
- Streaming, out_ready=1: 4 beats with sel=0,1,2,3, inputs k=32'h1000_000k -> out_data 32'h1000_0000..32'h1000_0003 on consecutive cycles, 1-cycle latency, beat_cnt=4.
- Backpressure, out_ready=0 with 3 beats offered:
  - beat A is held on the output and beat B goes to the skid;
  - in_ready=0 and beat C waits.
  - Raising out_ready drains A, B, C in order with no loss or duplication.
- Reset mid-stall: assert rst with out_valid=1 and skid_valid=1 -> all cleared immediately (async), in_ready=1, no stale beat after release.
- Counter wrap: with CNT_W=4, accept 17 beats -> beat_cnt=1.
- Bad select, N_IN=3, sel=3 -> out_data=0.
  - With MUX_PIPE_SEL_CHECK_EN: sel_err=1 and stays set.
  - Without MUX_PIPE_SEL_CHECK_EN: sel_err=0.

Source files
------------

// File: rtl/mux_pipe_pkg.sv
// Shared constants and select-width helper for the mux_pipe_n operand select slice.
// Purely declarative: no logic, no latency, no flow control.
package mux_pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

  // A one-bit select is kept even for degenerate N so that port widths never collapse to zero.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_comb_n.sv
// N-way WIDTH-bit combinational select; an out-of-range select yields all-zero data.
// Zero latency, no handshake (the caller owns flow control).
module mux_comb_n
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = 4,
  parameter int SEL_W = sel_width(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WIDTH-1:0]      data_o
);

  always_comb begin
    data_o = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel_i == SEL_W'(k)) data_o = data_i[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// Registered N-way operand select, 1-cycle latency; a 1-entry skid keeps in_ready a pure register.
// Stalls hold out_data/out_sel; optional out-of-range select flag under MUX_PIPE_SEL_CHECK_EN.
module mux_pipe_n
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_IN  = 4,
  parameter int SEL_W = sel_width(N_IN),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic [CNT_W-1:0]      beat_cnt,
  output logic                  sel_err
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0] mux_dat;
  logic             acc;

  mux_comb_n #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_mux (
    .data_i (in_data),
    .sel_i  (sel),
    .data_o (mux_dat)
  );

  assign acc = in_valid & ~skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    beat_cnt_d   = beat_cnt_q;
    if (skid_valid_q && out_ready) begin
      out_data_d   = skid_data_q;
      out_sel_d    = skid_sel_q;
      skid_valid_d = 1'b0;
    end else if (acc && (!out_valid_q || out_ready)) begin
      out_data_d  = mux_dat;
      out_sel_d   = sel;
      out_valid_d = 1'b1;
    end else if (acc && out_valid_q && !out_ready) begin
      skid_data_d  = mux_dat;
      skid_sel_d   = sel;
      skid_valid_d = 1'b1;
    end else if (out_valid_q && out_ready && !acc && !skid_valid_q) begin
      out_valid_d = 1'b0;
    end
    if (acc) beat_cnt_d = beat_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
      beat_cnt_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

`ifdef MUX_PIPE_SEL_CHECK_EN
  logic sel_err_q, sel_err_d;

  // Widened compare so N_IN == 2**SEL_W still fits on the right-hand side.
  assign sel_err_d = sel_err_q | (acc & ({1'b0, sel} >= (SEL_W+1)'(N_IN)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: a 4-way/16-bit-counter instance and a 3-way/4-bit-counter instance share stimulus.
// Reference model: a 2-deep FIFO of expected beats plus an accept counter and sticky error flag.
module tb_mux_pipe_n;

  localparam bit SEL_CHK =
`ifdef MUX_PIPE_SEL_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [1:0]   sel;
  logic [127:0] in_data;
  logic [31:0]  w [4];

  logic         in_ready, out_valid, sel_err;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic [15:0]  beat_cnt;
  logic         in_ready3, out_valid3, sel_err3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;
  logic [3:0]   beat_cnt3;

  int checks = 0;
  int failures = 0;

  mux_pipe_n #(.WIDTH(32), .N_IN(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .beat_cnt(beat_cnt), .sel_err(sel_err)
  );

  mux_pipe_n #(.WIDTH(32), .N_IN(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .sel(sel),
    .in_data(in_data[95:0]), .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_sel(out_sel3), .beat_cnt(beat_cnt3), .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: up to two beats in flight, accept only when fewer than two are held.
  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    logic [31:0] d3;
  } beat_t;

  beat_t       q[$];
  beat_t       nb;
  logic [31:0] acc_n;
  logic        err_exp;
  bit          room;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      acc_n   = 0;
      err_exp = 1'b0;
    end else begin
      room = (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && room) begin
        nb.d  = w[sel];
        nb.s  = sel;
        nb.d3 = (sel < 3) ? w[sel] : 32'h0;
        q.push_back(nb);
        acc_n = acc_n + 1;
        if (sel >= 3 && SEL_CHK) err_exp = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [31:0] a, b, c, d);
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    in_data = {w[3], w[2], w[1], w[0]};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0;
    set_words(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (3) tick();
    checks++;
    if ({out_valid, out_valid3, in_ready, in_ready3} !== 4'b0011) begin
      failures++;
      $display("FAIL reset_hs got vld=%b/%b rdy=%b/%b want 0/0 1/1", out_valid, out_valid3, in_ready, in_ready3);
    end
    checks++;
    if ({beat_cnt, beat_cnt3, out_data, out_data3, out_sel, sel_err, sel_err3} !== '0) begin
      failures++;
      $display("FAIL reset_regs got cnt=%0d/%0d dat=%h/%h sel=%0d err=%b/%b want all zero",
               beat_cnt, beat_cnt3, out_data, out_data3, out_sel, sel_err, sel_err3);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({out_valid, in_ready, beat_cnt} !== {1'b0, 1'b1, 16'd0}) begin
      failures++;
      $display("FAIL reset_idle got vld=%b rdy=%b cnt=%0d want 0 1 0", out_valid, in_ready, beat_cnt);
    end
  endtask

  task automatic test_stream();
    set_words(32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      sel = 2'(k);
      tick();
      checks++;
      if ({out_valid, in_ready, out_data, out_sel} !== {1'b1, 1'b1, 32'h1000_0000 + 32'(k), 2'(k)}) begin
        failures++;
        $display("FAIL stream_%0d got vld=%b rdy=%b dat=%h sel=%0d want 1 1 %h %0d",
                 k, out_valid, in_ready, out_data, out_sel, 32'h1000_0000 + 32'(k), k);
      end
      checks++;
      if ({out_valid3, out_data3} !== {1'b1, (k < 3) ? 32'h1000_0000 + 32'(k) : 32'h0}) begin
        failures++;
        $display("FAIL stream3_%0d got vld=%b dat=%h", k, out_valid3, out_data3);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, beat_cnt, beat_cnt3} !== {1'b0, 16'd4, 4'd4}) begin
      failures++;
      $display("FAIL stream_end got vld=%b cnt=%0d/%0d want 0 4/4", out_valid, beat_cnt, beat_cnt3);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] cnt0;
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    set_words(a, b, c, $urandom);
    cnt0 = beat_cnt;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 2'd0;
    tick();
    checks++;
    if ({out_valid, in_ready, out_data} !== {1'b1, 1'b1, a}) begin
      failures++;
      $display("FAIL bp_a got vld=%b rdy=%b dat=%h want 1 1 %h", out_valid, in_ready, out_data, a);
    end
    sel = 2'd1;
    tick();
    sel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, in_ready, in_ready3, out_data, out_data3, out_sel} !== {1'b1, 1'b0, 1'b0, a, a, 2'd0}) begin
        failures++;
        $display("FAIL bp_stall_%0d got vld=%b rdy=%b/%b dat=%h/%h sel=%0d want 1 0/0 %h 0",
                 i, out_valid, in_ready, in_ready3, out_data, out_data3, out_sel, a);
      end
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if ({in_ready, out_data, out_data3, out_sel} !== {1'b0, a, a, 2'd0}) begin
      failures++;
      $display("FAIL bp_hold got rdy=%b dat=%h sel=%0d want 0 %h 0", in_ready, out_data, out_sel, a);
    end
    tick();
    checks++;
    if ({out_valid, in_ready, out_data, out_data3, out_sel} !== {1'b1, 1'b1, b, b, 2'd1}) begin
      failures++;
      $display("FAIL bp_drain_b got vld=%b rdy=%b dat=%h sel=%0d want 1 1 %h 1", out_valid, in_ready, out_data, out_sel, b);
    end
    tick();
    checks++;
    if ({out_valid, out_data, out_data3, out_sel} !== {1'b1, c, c, 2'd2}) begin
      failures++;
      $display("FAIL bp_drain_c got vld=%b dat=%h sel=%0d want 1 %h 2", out_valid, out_data, out_sel, c);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_valid3, beat_cnt} !== {1'b0, 1'b0, cnt0 + 16'd3}) begin
      failures++;
      $display("FAIL bp_end got vld=%b/%b cnt=%0d want 0/0 %0d", out_valid, out_valid3, beat_cnt, cnt0 + 16'd3);
    end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel = 2'd1;
    set_words($urandom, $urandom, $urandom, $urandom);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_valid3, in_ready, in_ready3, beat_cnt, out_data, out_sel} !== {4'b0011, 16'd0, 32'd0, 2'd0}) begin
      failures++;
      $display("FAIL rst_stall got vld=%b/%b rdy=%b/%b cnt=%0d dat=%h sel=%0d want 0/0 1/1 0 0 0",
               out_valid, out_valid3, in_ready, in_ready3, beat_cnt, out_data, out_sel);
    end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, out_valid3, in_ready} !== 3'b001) begin
        failures++;
        $display("FAIL rst_release_%0d got vld=%b/%b rdy=%b want 0/0 1", i, out_valid, out_valid3, in_ready);
      end
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel = 2'd0;
    repeat (17) tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({beat_cnt3, beat_cnt} !== {4'd1, 16'd17}) begin
      failures++;
      $display("FAIL wrap got cnt3=%0d cnt=%0d want 1 17", beat_cnt3, beat_cnt);
    end
  endtask

  task automatic test_bad_sel();
    logic [31:0] d3v;
    d3v = $urandom | 32'h1;
    set_words($urandom, $urandom, $urandom, d3v);
    checks++;
    if ({sel_err, sel_err3} !== 2'b00) begin
      failures++;
      $display("FAIL badsel_pre got err=%b/%b want 0/0", sel_err, sel_err3);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel = 2'd3;
    tick();
    checks++;
    if ({out_valid3, out_data3, out_sel3, sel_err3} !== {1'b1, 32'h0, 2'd3, SEL_CHK}) begin
      failures++;
      $display("FAIL badsel_3 got vld=%b dat=%h sel=%0d err=%b want 1 0 3 %b", out_valid3, out_data3, out_sel3, sel_err3, SEL_CHK);
    end
    checks++;
    if ({out_data, sel_err} !== {d3v, 1'b0}) begin
      failures++;
      $display("FAIL badsel_4way got dat=%h err=%b want %h 0", out_data, sel_err, d3v);
    end
    sel = 2'd0;
    repeat (4) tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({sel_err3, sel_err} !== {SEL_CHK, 1'b0}) begin
      failures++;
      $display("FAIL badsel_sticky got err3=%b err=%b want %b 0", sel_err3, sel_err, SEL_CHK);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel = 2'($urandom);
      set_words($urandom, $urandom, $urandom, $urandom);
      tick();
      checks++;
      if ({in_ready, in_ready3, out_valid, out_valid3} !== {{2{q.size() < 2}}, {2{q.size() > 0}}}) begin
        failures++;
        $display("FAIL rand_hs_%0d got rdy=%b/%b vld=%b/%b model_depth=%0d", i, in_ready, in_ready3, out_valid, out_valid3, q.size());
      end
      if (q.size() > 0) begin
        checks++;
        if ({out_data, out_sel, out_data3, out_sel3} !== {q[0].d, q[0].s, q[0].d3, q[0].s}) begin
          failures++;
          $display("FAIL rand_dat_%0d got %h/%0d %h/%0d want %h/%0d %h/%0d",
                   i, out_data, out_sel, out_data3, out_sel3, q[0].d, q[0].s, q[0].d3, q[0].s);
        end
      end
      checks++;
      if ({beat_cnt, beat_cnt3, sel_err, sel_err3} !== {acc_n[15:0], acc_n[3:0], 1'b0, err_exp}) begin
        failures++;
        $display("FAIL rand_cnt_%0d got cnt=%0d/%0d err=%b/%b want %0d/%0d 0/%b",
                 i, beat_cnt, beat_cnt3, sel_err, sel_err3, acc_n[15:0], acc_n[3:0], err_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_reset_stall();
    test_wrap();
    test_bad_sel();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
